mux_scan_ctrl: RTL

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_ctrl_pkg.sv | 21 ++
 rtl/mux_16_1.sv | 10 +
 rtl/mux_scan_ctrl.sv | 81 ++++++++
 3 files changed

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the bit-scan controller: FSM encoding and scan index
// bounds.
package mux_scan_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

  localparam logic [3:0] IDX_LSB = 4'd0;
  localparam logic [3:0] IDX_MSB = 4'd15;

  function automatic logic [3:0] first_idx(input int msb_first);
    return (msb_first != 0) ? IDX_MSB : IDX_LSB;
  endfunction

  function automatic logic [3:0] last_idx(input int msb_first);
    return (msb_first != 0) ? IDX_LSB : IDX_MSB;
  endfunction

endpackage

// File: rtl/mux_16_1.sv
// Plain 16:1 bit multiplexer, combinational.
module mux_16_1 (
  output logic        out,
  input  logic [15:0] in,
  input  logic [3:0]  sel
);

  assign out = in[sel];

endmodule

// File: rtl/mux_scan_ctrl.sv
// Serialises a 16-bit word one bit per output handshake through a 16:1 mux.
// Back-to-back words are accepted on the last-bit transfer so the stream has no bubble.
//
// state | meaning
// IDLE  | waiting for a word, in_ready=1
// SCAN  | presenting held_word[sel], stepping sel on each output transfer
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int MSB_FIRST = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [3:0]  sel,
  output logic        out_bit,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy
);

  localparam logic [3:0] FIRST_IDX = first_idx(MSB_FIRST);
  localparam logic [3:0] LAST_IDX  = last_idx(MSB_FIRST);

  scan_state_t state;
  logic [15:0] held_word;
  logic        mux_out;
  logic        in_xfer;
  logic        out_xfer;

  mux_16_1 u_mux (
    .out (mux_out),
    .in  (held_word),
    .sel (sel)
  );

  // Outputs are forced inactive while reset is held, even before the edge.
  always_comb begin
    out_valid = (state == ST_SCAN) && !reset;
    busy      = out_valid;
    out_last  = out_valid && (sel == LAST_IDX);
    in_ready  = !reset && ((state == ST_IDLE) || (out_last && out_ready));
    out_bit   = mux_out & out_valid;
    in_xfer   = in_valid && in_ready;
    out_xfer  = out_valid && out_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      held_word <= 16'h0000;
      sel       <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_xfer) begin
            held_word <= in_data;
            sel       <= FIRST_IDX;
            state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (in_xfer) begin
            held_word <= in_data;
            sel       <= FIRST_IDX;
          end else if (out_xfer) begin
            if (out_last)
              state <= ST_IDLE;
            else
              sel <= (MSB_FIRST != 0) ? (sel - 4'd1) : (sel + 4'd1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
